tt_mem_arbiter: RTL and testbench
=================================

# tt_mem_arbiter

Two-port arbiter and sequencer for the Tiny Tapeout time-multiplexed 16-bit external memory bus. It accepts commands from an instruction-fetch port (p0, read-only) and a load/store port (p1, read/write). It serialises them onto the 2-cycle ADDR/DATA pin protocol on `uo_out`/`uio_out`/`uio_oe`/`ui_in`/`uio_in`, and returns read data and write completions. It sits between the core's memory stages and the chip pins, and replaces direct single-master pin driving.

## Interface
- `RR_ENABLE`, default 1: 1 = round-robin between p0 and p1; 0 = fixed priority, p1 over p0.
- `FORCE_ALIGN`, default 1: 1 = bit 0 of every address is driven as 0 on the pins and `misalign` is flagged; 0 = address passed unchanged, `misalign` never set.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `p0_valid`  in  1: fetch read command valid.
- `p0_ready`  out  1: fetch command accepted this cycle.
- `p0_addr`  in  16: fetch byte address.
- `p0_rvalid`  out  1: one-cycle pulse; `rdata` holds the fetch result.
- `p1_valid`  in  1: load/store command valid.
- `p1_ready`  out  1: load/store command accepted this cycle.
- `p1_addr`  in  16: load/store byte address.
- `p1_we`  in  1: 1 = write, 0 = read.
- `p1_wdata`  in  16: write data.
- `p1_rvalid`  out  1: one-cycle pulse; read data (or write done) for p1.
- `rdata`  out  16: registered read data, shared by both ports.
- `misalign`  out  1: sticky flag, set when an accepted address has bit0=1 and `FORCE_ALIGN`=1; cleared only by reset.
- `uo_out`  out  8: bus low byte (address or write data).
- `uio_out`  out  8: bus high byte (address or write data).
- `uio_oe`  out  8: 8'hFF = arbiter drives the upper byte; 8'h00 = upper byte released.
- `ui_in`  in  8: read data low byte.
- `uio_in`  in  8: read data high byte.

## Operation
- FSM states: IDLE, ADDR, DATA. Registered command state:
  - `addr_q`, `wdata_q`, `we_q` (p0 commands always load `we_q`=0)
  - `owner_q`: the port being served
  - `last_q`: the port last granted
- Acceptance window: state is IDLE or DATA.
  - Grant picks one port with `valid`=1. `ready` for that port is asserted combinationally.
  - The command registers load on that edge, and the next state is ADDR.
  - With no valid request, IDLE→IDLE and DATA→IDLE.
- Arbitration:
  - RR_ENABLE=1: if both ports are valid, grant the port that is not `last_q`. `last_q` updates on every grant.
  - RR_ENABLE=0: p1 always wins.
  - A single valid port is always granted.
- Pin drive:
  - IDLE: `uio_oe`=00; `uo_out`=`uio_out`=00.
  - ADDR: `uio_oe`=FF; {`uio_out`,`uo_out`}=`addr_q`, with bit0 forced to 0 if FORCE_ALIGN.
  - DATA, read: `uio_oe`=00; pins low.
  - DATA, write: `uio_oe`=FF; {`uio_out`,`uo_out`}=`wdata_q`.
  - `uio_oe` is only ever 00 or FF. It is never FF in IDLE, because the external side treats any FF cycle after idle as an ADDR phase.
- Completion:
  - At the edge ending DATA: reads register {`uio_in`,`ui_in`} into `rdata`; writes leave `rdata` unchanged.
  - The next cycle, `pX_rvalid` pulses for `owner_q`.
- Requesters hold `valid`/`addr`/`we`/`wdata` stable until `ready`. They may change them in the cycle after `ready`.
- Reset mid-transfer: the transfer is abandoned. No `rvalid` is issued and the pins are released immediately (asynchronously).

## Timing
- Reset values:
  - state IDLE; `uio_oe`=00, `uo_out`=00, `uio_out`=00
  - `p0_ready`=`p1_ready`=0, `p0_rvalid`=`p1_rvalid`=0
  - `rdata`=0000, `misalign`=0
  - `last_q`=p1, so p0 wins the first tie
  - `addr_q`/`wdata_q`/`we_q`=0
- Isolated read, `valid` in IDLE at cycle t:
  - `ready` at t
  - ADDR at t+1, DATA at t+2
  - `rvalid` and `rdata` at t+3
- Back-to-back: a command accepted during DATA at t+2 gives ADDR at t+3. Sustained throughput is one transfer per 2 cycles.
- A `rvalid` pulse may coincide with an ADDR cycle of the next transfer.
- `ready` is never asserted in ADDR. At most one `ready` and at most one `rvalid` per cycle.
- Pins are combinational from registered state only, with no combinational path from `pX_valid`.

## Test plan
- Single p0 read:
  - Setup: mem[0x0010>>1]=0xBEEF; `p0_valid` with addr 0x0010 in IDLE.
  - Required: ADDR pins 0x0010 with oe FF; DATA oe 00; `p0_rvalid` at t+3 with `rdata`=0xBEEF.
- p1 write then read:
  - Stimulus: write 0x1234 to 0x0100, then read 0x0100.
  - Required: DATA of the write drives 0x1234 with oe FF; the read returns 0x1234; no IDLE cycle between the two transfers.
- Contention, RR_ENABLE=1:
  - Stimulus: both ports continuously valid for 8 transfers.
  - Required: grants alternate p0,p1,p0,…; one ADDR every 2 cycles; `uio_oe` never FF in an IDLE cycle.
- Fixed priority, RR_ENABLE=0:
  - Stimulus: both ports valid for 3 transfers.
  - Required: all 3 grants go to p1; p0 is granted once p1 drops `valid`.
- Misalign:
  - Stimulus: p1 read at 0x0011, FORCE_ALIGN=1.
  - Required: pins show 0x0010; `misalign`=1 and stays 1 until `rst`.
- Reset mid-DATA:
  - Stimulus: assert `rst` during the DATA cycle of a write.
  - Required: `uio_oe`=00 immediately; no `rvalid`; after release, the first tie is granted to p0.

Source files
------------

// File: rtl/tt_mem_arbiter.sv
// Two-port arbiter/sequencer for the Tiny Tapeout time-multiplexed 16-bit memory bus.
// Port 0 is a read-only fetch port, port 1 a load/store port; transfers are 2-cycle ADDR/DATA.
module tt_mem_arbiter #(
  parameter bit RR_ENABLE   = 1'b1,
  parameter bit FORCE_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [15:0] p0_addr,
  output logic        p0_rvalid,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [15:0] p1_addr,
  input  logic        p1_we,
  input  logic [15:0] p1_wdata,
  output logic        p1_rvalid,
  output logic [15:0] rdata,
  output logic        misalign,
  output logic [7:0]  uo_out,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
  typedef enum logic {PORT0, PORT1} port_e;

  state_e      state_q;
  port_e       owner_q, last_q;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic        we_q, misalign_q, p0_rvalid_q, p1_rvalid_q;

  port_e       grant_d;
  logic        accept_d;
  logic [15:0] addr_d;
  logic        we_d;
  logic        drive_d;
  logic [15:0] bus_d;

  // Arbitration and handshake: commands are taken in IDLE or in the DATA cycle of the previous transfer.
  always_comb begin
    grant_d = PORT0;
    if (p0_valid && p1_valid) begin
      grant_d = (RR_ENABLE && (last_q == PORT1)) ? PORT0 : PORT1;
    end else if (p1_valid) begin
      grant_d = PORT1;
    end
    accept_d = !rst && ((state_q == S_IDLE) || (state_q == S_DATA)) && (p0_valid || p1_valid);
    p0_ready = accept_d && (grant_d == PORT0);
    p1_ready = accept_d && (grant_d == PORT1);
    addr_d   = (grant_d == PORT1) ? p1_addr : p0_addr;
    we_d     = (grant_d == PORT1) && p1_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= PORT0;
      last_q      <= PORT1;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      p0_rvalid_q <= (state_q == S_DATA) && (owner_q == PORT0);
      p1_rvalid_q <= (state_q == S_DATA) && (owner_q == PORT1);
      if ((state_q == S_DATA) && !we_q) begin
        rdata_q <= {uio_in, ui_in};
      end
      if (accept_d) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        owner_q <= grant_d;
        last_q  <= grant_d;
        if (grant_d == PORT1) begin
          wdata_q <= p1_wdata;
        end
        if (FORCE_ALIGN && addr_d[0]) begin
          misalign_q <= 1'b1;
        end
      end
      unique case (state_q)
        S_ADDR:  state_q <= S_DATA;
        default: state_q <= accept_d ? S_ADDR : S_IDLE;
      endcase
    end
  end

  // Pins depend only on registered state so reset releases them asynchronously.
  always_comb begin
    drive_d = 1'b0;
    bus_d   = '0;
    unique case (state_q)
      S_ADDR: begin
        drive_d = 1'b1;
        bus_d   = {addr_q[15:1], addr_q[0] & ~FORCE_ALIGN};
      end
      S_DATA: begin
        if (we_q) begin
          drive_d = 1'b1;
          bus_d   = wdata_q;
        end
      end
      default: begin
        drive_d = 1'b0;
        bus_d   = '0;
      end
    endcase
  end

  assign uo_out    = bus_d[7:0];
  assign uio_out   = bus_d[15:8];
  assign uio_oe    = {8{drive_d}};
  assign rdata     = rdata_q;
  assign misalign  = misalign_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;

endmodule

// File: tb/tb_tt_mem_arbiter.sv
// Bench for tt_mem_arbiter: instance 0 round-robin, instance 1 fixed priority, both FORCE_ALIGN=1.
module tb_tt_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        p0_valid[2], p0_ready[2], p0_rvalid[2];
  logic        p1_valid[2], p1_ready[2], p1_we[2], p1_rvalid[2], misalign[2];
  logic [15:0] p0_addr[2], p1_addr[2], p1_wdata[2], rdata[2];
  logic [7:0]  uo_out[2], uio_out[2], uio_oe[2], ui_in[2], uio_in[2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", nm, k, cyc, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    tt_mem_arbiter #(.RR_ENABLE(k == 0), .FORCE_ALIGN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid[k]), .p0_ready(p0_ready[k]), .p0_addr(p0_addr[k]), .p0_rvalid(p0_rvalid[k]),
      .p1_valid(p1_valid[k]), .p1_ready(p1_ready[k]), .p1_addr(p1_addr[k]), .p1_we(p1_we[k]),
      .p1_wdata(p1_wdata[k]), .p1_rvalid(p1_rvalid[k]), .rdata(rdata[k]), .misalign(misalign[k]),
      .uo_out(uo_out[k]), .uio_out(uio_out[k]), .uio_oe(uio_oe[k]), .ui_in(ui_in[k]), .uio_in(uio_in[k])
    );

    // External memory device: first FF cycle after idle/data is ADDR, the following cycle is DATA.
    logic        dev_data;
    logic [15:0] dev_addr;
    logic [15:0] mem [256];
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        dev_data <= 1'b0;
        dev_addr <= '0;
        mem[8]   <= 16'hBEEF;
      end else if (dev_data) begin
        if (uio_oe[k] == 8'hFF) mem[dev_addr[8:1]] <= {uio_out[k], uo_out[k]};
        dev_data <= 1'b0;
      end else if (uio_oe[k] == 8'hFF) begin
        dev_addr <= {uio_out[k], uo_out[k]};
        dev_data <= 1'b1;
      end
    end
    assign ui_in[k]  = dev_data ? mem[dev_addr[8:1]][7:0]  : 8'h00;
    assign uio_in[k] = dev_data ? mem[dev_addr[8:1]][15:8] : 8'h00;
  end

  // Transaction-level model: each accepted command books its future pin/completion cycles.
  typedef struct {
    logic        oe;
    logic [15:0] pins;
    logic        rv0, rv1, upd, wr;
    logic [15:0] rd, waddr, wdat;
  } slot_t;

  slot_t       sl[2][16];
  int          free_at[2];
  int          last_g[2];
  logic [15:0] sh[2][256];
  logic [15:0] rd_exp[2];
  logic        mis_exp[2];
  int          gl0[$], gl1[$];

  always @(negedge clk) begin
    slot_t       s;
    int          gp, idx;
    logic [15:0] a;
    logic        we, e0, e1;
    idx = cyc % 16;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) sl[k][i] = '{default: '0};
        free_at[k] = 0;
        last_g[k]  = 1;
        rd_exp[k]  = '0;
        mis_exp[k] = 1'b0;
        sh[k][8]   = 16'hBEEF;
        chk("rst_oe", k, uio_oe[k], 8'h00);
        chk("rst_pins", k, {uio_out[k], uo_out[k]}, 16'h0000);
        chk("rst_rvalid", k, {p0_rvalid[k], p1_rvalid[k]}, 2'b00);
        chk("rst_rdata", k, rdata[k], 16'h0000);
        chk("rst_misalign", k, misalign[k], 1'b0);
        chk("rst_ready", k, {p0_ready[k], p1_ready[k]}, 2'b00);
      end else begin
        s = sl[k][idx];
        sl[k][idx] = '{default: '0};
        if (s.upd) rd_exp[k] = s.rd;
        if (s.wr) sh[k][s.waddr[8:1]] = s.wdat;
        chk("oe", k, uio_oe[k], s.oe ? 8'hFF : 8'h00);
        chk("pins", k, {uio_out[k], uo_out[k]}, s.pins);
        chk("rvalid", k, {p0_rvalid[k], p1_rvalid[k]}, {s.rv0, s.rv1});
        chk("rdata", k, rdata[k], rd_exp[k]);
        chk("misalign", k, misalign[k], mis_exp[k]);
        e0 = 1'b0;
        e1 = 1'b0;
        if (cyc >= free_at[k] && (p0_valid[k] || p1_valid[k])) begin
          if (p0_valid[k] && p1_valid[k]) gp = (k == 0) ? 1 - last_g[k] : 1;
          else gp = p1_valid[k] ? 1 : 0;
          a  = (gp == 1) ? p1_addr[k] : p0_addr[k];
          we = (gp == 1) && p1_we[k];
          sl[k][(cyc + 1) % 16].oe   = 1'b1;
          sl[k][(cyc + 1) % 16].pins = {a[15:1], 1'b0};
          sl[k][(cyc + 2) % 16].oe   = we;
          sl[k][(cyc + 2) % 16].pins = we ? p1_wdata[k] : 16'h0000;
          sl[k][(cyc + 2) % 16].wr   = we;
          sl[k][(cyc + 2) % 16].waddr = a;
          sl[k][(cyc + 2) % 16].wdat = p1_wdata[k];
          sl[k][(cyc + 3) % 16].rv0  = (gp == 0);
          sl[k][(cyc + 3) % 16].rv1  = (gp == 1);
          sl[k][(cyc + 3) % 16].upd  = !we;
          sl[k][(cyc + 3) % 16].rd   = sh[k][a[8:1]];
          if (a[0]) mis_exp[k] = 1'b1;
          free_at[k] = cyc + 2;
          last_g[k]  = gp;
          if (k == 0) gl0.push_back(gp);
          else gl1.push_back(gp);
          e0 = (gp == 0);
          e1 = (gp == 1);
        end
        chk("ready", k, {p0_ready[k], p1_ready[k]}, {e0, e1});
      end
    end
  end

  task automatic issue(input int k, input int port, input logic [15:0] a, input logic we,
                       input logic [15:0] wd);
    logic got;
    got = 1'b0;
    if (port == 0) begin
      p0_addr[k]  = a;
      p0_valid[k] = 1'b1;
    end else begin
      p1_addr[k]  = a;
      p1_we[k]    = we;
      p1_wdata[k] = wd;
      p1_valid[k] = 1'b1;
    end
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if ((port == 0) ? p0_ready[k] : p1_ready[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("handshake_timeout", k, 0, 1);
    @(posedge clk);
    #1;
    if (port == 0) p0_valid[k] = 1'b0;
    else p1_valid[k] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gs;
    logic [3:0] fp_pat;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      p0_valid[k] = 1'b0; p0_addr[k] = '0;
      p1_valid[k] = 1'b0; p1_addr[k] = '0; p1_we[k] = 1'b0; p1_wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    next_cycle();

    // Single p0 read at 0x0010 (mem holds 0xBEEF)
    issue(0, 0, 16'h0010, 1'b0, 16'h0000);
    chk("t1_addr_pins", 0, {uio_out[0], uo_out[0]}, 16'h0010);
    chk("t1_addr_oe", 0, uio_oe[0], 8'hFF);
    next_cycle();
    chk("t1_data_oe", 0, uio_oe[0], 8'h00);
    next_cycle();
    chk("t1_rvalid", 0, p0_rvalid[0], 1'b1);
    chk("t1_rdata", 0, rdata[0], 16'hBEEF);

    // p1 write 0x1234 to 0x0100, read issued during the write's DATA cycle
    issue(0, 1, 16'h0100, 1'b1, 16'h1234);
    next_cycle();
    chk("t2_wdata_pins", 0, {uio_out[0], uo_out[0]}, 16'h1234);
    chk("t2_wdata_oe", 0, uio_oe[0], 8'hFF);
    issue(0, 1, 16'h0100, 1'b0, 16'h0000);
    chk("t2_no_idle_gap", 0, uio_oe[0], 8'hFF);
    next_cycle();
    next_cycle();
    chk("t2_rvalid", 0, p1_rvalid[0], 1'b1);
    chk("t2_rdata", 0, rdata[0], 16'h1234);

    // Round-robin contention, 8 transfers
    gs = gl0.size();
    fork
      for (int i = 0; i < 4; i++) issue(0, 0, 16'h0010, 1'b0, 16'h0000);
      for (int i = 0; i < 4; i++) issue(0, 1, 16'h0100, 1'b0, 16'h0000);
    join
    repeat (4) next_cycle();
    chk("t3_grant_count", 0, gl0.size() - gs, 8);
    for (int i = 0; i < 8 && gs + i < gl0.size(); i++) chk("t3_rr_grant", 0, gl0[gs + i], i % 2);

    // Fixed priority on instance 1
    gs = gl1.size();
    fp_pat = 4'b0111;
    fork
      issue(1, 0, 16'h0010, 1'b0, 16'h0000);
      for (int i = 0; i < 3; i++) issue(1, 1, 16'h0010, 1'b0, 16'h0000);
    join
    repeat (4) next_cycle();
    chk("t4_grant_count", 1, gl1.size() - gs, 4);
    for (int i = 0; i < 4 && gs + i < gl1.size(); i++) chk("t4_fp_grant", 1, gl1[gs + i], fp_pat[i]);

    // Misaligned p1 read at 0x0011
    issue(0, 1, 16'h0011, 1'b0, 16'h0000);
    chk("t5_aligned_pins", 0, {uio_out[0], uo_out[0]}, 16'h0010);
    chk("t5_misalign", 0, misalign[0], 1'b1);
    next_cycle();
    next_cycle();
    chk("t5_rdata", 0, rdata[0], 16'hBEEF);
    repeat (3) next_cycle();
    chk("t5_misalign_sticky", 0, misalign[0], 1'b1);

    // Reset during the DATA cycle of a write
    issue(0, 1, 16'h0020, 1'b1, 16'h5555);
    @(posedge clk);
    #1;
    chk("t6_data_oe", 0, uio_oe[0], 8'hFF);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_oe", 0, uio_oe[0], 8'h00);
    chk("t6_async_pins", 0, {uio_out[0], uo_out[0]}, 16'h0000);
    chk("t6_misalign_cleared", 0, misalign[0], 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    gs = gl0.size();
    fork
      issue(0, 0, 16'h0010, 1'b0, 16'h0000);
      issue(0, 1, 16'h0010, 1'b0, 16'h0000);
    join
    repeat (4) next_cycle();
    chk("t6_grant_count", 0, gl0.size() - gs, 2);
    if (gl0.size() > gs) chk("t6_first_tie_p0", 0, gl0[gs], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
